// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac
// Purpose  : Time-multiplexed neuron. Serially multiply-accumulates N_IN
//            unsigned input/weight lane pairs on one multiplier, then applies
//            a threshold or saturating linear activation.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_mac #(
  parameter int N_IN  = 4,
  parameter int DW    = 16,
  parameter int ACC_W = 2*DW + $clog2(N_IN) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN*DW-1:0] x_vec,
  input  logic [N_IN*DW-1:0] w_vec,
  input  logic [DW-1:0]      sigma,
  input  logic               act_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      y,
  output logic               sat,
  output logic               busy
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SC_W  = ACC_W - DW;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_ACT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [DW-1:0]     x_q [N_IN];
  logic [DW-1:0]     w_q [N_IN];
  logic [DW-1:0]     sigma_q;
  logic              mode_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DW-1:0]     y_q;
  logic [DW-1:0]     y_d;
  logic              sat_q;
  logic              sat_d;

  logic              capture;
  logic [2*DW-1:0]   prod;
  logic [SC_W-1:0]   scaled;
  logic [DW-1:0]     clip;

  assign capture = in_valid && (state_q == S_IDLE);

  // Full-width product of the current lane; operands widened so the
  // multiply is evaluated at 2*DW bits.
  assign prod  = {{DW{1'b0}}, x_q[idx_q]} * {{DW{1'b0}}, w_q[idx_q]};
  assign acc_d = acc_q + {{(ACC_W-2*DW){1'b0}}, prod};

  // Drop the fractional DW bits, then clamp anything that does not fit DW.
  assign scaled = acc_q[ACC_W-1:DW];
  assign sat_d  = |scaled[SC_W-1:DW];
  assign clip   = sat_d ? {DW{1'b1}} : scaled[DW-1:0];

  // Threshold passes only values strictly above sigma; linear ignores sigma.
  assign y_d = (mode_q || (clip > sigma_q)) ? clip : {DW{1'b0}};

  // Operand capture: lane data is only loaded on an accepted input vector.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N_IN; i++) begin
        x_q[i] <= x_vec[i*DW +: DW];
        w_q[i] <= w_vec[i*DW +: DW];
      end
      sigma_q <= sigma;
      mode_q  <= act_mode;
    end
  end

  // Control FSM with accumulator, lane index and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (idx_q == LAST_IDX) begin
            state_q <= S_ACT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_ACT: begin
          y_q     <= y_d;
          sat_q   <= sat_d;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign y         = y_q;
  assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_mac
// Purpose  : Self-checking bench for neuron_mac (N_IN=4, DW=16): table of
//            vectors through a scoreboard plus backpressure and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_mac;

  localparam int N_IN = 4;
  localparam int DW   = 16;
  localparam int LAT  = N_IN + 1;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [N_IN*DW-1:0] x_vec;
  logic [N_IN*DW-1:0] w_vec;
  logic [DW-1:0]      sigma;
  logic               act_mode;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      y;
  logic               sat;
  logic               busy;

  neuron_mac #(.N_IN(N_IN), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_vec     (x_vec),
    .w_vec     (w_vec),
    .sigma     (sigma),
    .act_mode  (act_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .sat       (sat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] x;
    logic [63:0] w;
    logic [15:0] sg;
    logic        md;
    logic [15:0] ey;
    logic        es;
  } vec_t;

  typedef struct {
    logic [15:0] ey;
    logic        es;
    int          cap;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Independent reference: 64-bit sum, shift, clamp, activation.
  function automatic logic [16:0] model(input logic [63:0] xv, input logic [63:0] wv,
                                        input logic [15:0] sg, input logic md);
    longint unsigned s, a, b, sc;
    logic [15:0] clip;
    logic        st;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      a = {48'd0, xv[i*16 +: 16]};
      b = {48'd0, wv[i*16 +: 16]};
      s = s + a * b;
    end
    sc = s >> 16;
    if (sc > 64'hFFFF) begin
      clip = 16'hFFFF;
      st   = 1'b1;
    end else begin
      clip = sc[15:0];
      st   = 1'b0;
    end
    if (md || clip > sg) return {st, clip};
    return {st, 16'h0000};
  endfunction

  // Output monitor: latency on each rising out_valid, data at each handshake.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      else check("latency", cyc - sb[0].cap, LAT);
    end
    if (out_valid && out_ready && sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      check("y", {16'd0, y}, {16'd0, e.ey});
      check("sat", {31'd0, sat}, {31'd0, e.es});
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [63:0] xv, input logic [63:0] wv, input logic [15:0] sg,
                      input logic md, input logic [15:0] ey, input logic es, input bit push);
    int n;
    @(negedge clk);
    x_vec    = xv;
    w_vec    = wv;
    sigma    = sg;
    act_mode = md;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{ey: ey, es: es, cap: cyc + 1});
    @(negedge clk);
    // Scramble the ports after capture: the block must ignore them now.
    in_valid = 1'b0;
    x_vec    = {$urandom, $urandom};
    w_vec    = {$urandom, $urandom};
    sigma    = 16'($urandom);
    act_mode = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  localparam logic [63:0] X_BASIC = {4{16'h4000}};
  localparam logic [63:0] W_BASIC = {4{16'h8000}};
  localparam logic [63:0] X_LANE  = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
  localparam logic [63:0] W_LANE  = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
  localparam logic [63:0] ALL1    = {4{16'hFFFF}};

  vec_t tbl[10];
  bit   b_done;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{x: X_BASIC, w: W_BASIC, sg: 16'h1000, md: 1'b0, ey: 16'h8000, es: 1'b0};
    tbl[1] = '{x: X_LANE,  w: W_LANE,  sg: 16'h0010, md: 1'b0, ey: 16'h0014, es: 1'b0};
    tbl[2] = '{x: X_LANE,  w: W_LANE,  sg: 16'h0014, md: 1'b0, ey: 16'h0000, es: 1'b0};
    tbl[3] = '{x: ALL1,    w: ALL1,    sg: 16'h0000, md: 1'b0, ey: 16'hFFFF, es: 1'b1};
    tbl[4] = '{x: ALL1,    w: ALL1,    sg: 16'h0000, md: 1'b1, ey: 16'hFFFF, es: 1'b1};
    tbl[5] = '{x: ALL1,    w: ALL1,    sg: 16'hFFFF, md: 1'b0, ey: 16'h0000, es: 1'b1};
    tbl[6] = '{x: 64'd1,   w: 64'h0000_0000_0000_FFFF, sg: 16'h0000, md: 1'b1, ey: 16'h0000, es: 1'b0};
    tbl[7] = '{x: 64'd2,   w: 64'h0000_0000_0000_FFFF, sg: 16'h0000, md: 1'b1, ey: 16'h0001, es: 1'b0};
    tbl[8] = '{x: 64'd0,   w: ALL1,    sg: 16'h0000, md: 1'b0, ey: 16'h0000, es: 1'b0};
    tbl[9] = '{x: X_LANE,  w: W_LANE,  sg: 16'hFFFF, md: 1'b1, ey: 16'h0014, es: 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x_vec     = '0;
    w_vec     = '0;
    sigma     = '0;
    act_mode  = 1'b0;
    out_ready = 1'b1;

    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_y", {16'd0, y}, 32'd0);
    check("rst_sat", {31'd0, sat}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, back to back with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].x, tbl[i].w, tbl[i].sg, tbl[i].md, tbl[i].ey, tbl[i].es, 1'b1);
    end
    drain();

    // Random vectors against the reference model.
    for (int i = 0; i < 6; i++) begin
      logic [63:0] xr, wr;
      logic [15:0] sr;
      logic        mr;
      logic [16:0] m;
      xr = {$urandom, $urandom};
      wr = {$urandom, $urandom};
      sr = 16'($urandom);
      mr = 1'($urandom);
      m  = model(xr, wr, sr, mr);
      send(xr, wr, sr, mr, m[15:0], m[16], 1'b1);
    end
    drain();

    // Backpressure: result A held in DONE while vector B is offered.
    @(posedge clk); #1 out_ready = 1'b0;
    send(X_LANE, W_LANE, 16'h0010, 1'b0, 16'h0014, 1'b0, 1'b1);
    b_done = 1'b0;
    fork
      begin
        send(X_BASIC, W_BASIC, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1);
        b_done = 1'b1;
      end
    join_none
    begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_y", {16'd0, y}, 32'h0014);
      check("bp_sat", {31'd0, sat}, 32'd0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_y_hold", {16'd0, y}, 32'h0014);
    begin
      int n;
      n = 0;
      while (!b_done && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!b_done) check("bp_second_capture", 32'd0, 32'd1);
    end
    drain();

    // Reset two cycles after capture: partial sum discarded.
    send(ALL1, ALL1, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_y", {16'd0, y}, 32'd0);
    check("mid_rst_sat", {31'd0, sat}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_result_after_rst", {31'd0, out_valid}, 32'd0);
    send(X_BASIC, W_BASIC, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/neuron_mac.md
# neuron_mac

Parametrised, time-multiplexed neuron for the FAPNN datapath. It accepts one vector of `N_IN` unsigned inputs and `N_IN` per-lane weights per transaction. It multiply-accumulates them serially on a single multiplier, then applies either a threshold activation or a linear activation with saturation. The block sits between the input/weight distribution logic and the next network layer, and uses valid/ready handshakes on both sides.

## Interface
Parameters:
- `N_IN`, default 4: number of input lanes; legal range 1..64.
- `DW`, default 16: width of each x, w, sigma and y value.
- `ACC_W`, default 2*DW+$clog2(N_IN)+1: accumulator width; this width guarantees no accumulator wrap.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- `in_valid`  in  1  an input vector is offered.
- `in_ready`  out  1  the block can capture an input vector.
- `x_vec`  in  N_IN*DW  input lanes; lane i is `x_vec[i*DW +: DW]`, unsigned.
- `w_vec`  in  N_IN*DW  weights; lane i is `w_vec[i*DW +: DW]`, unsigned.
- `sigma`  in  DW  activation threshold, unsigned.
- `act_mode`  in  1  0 = threshold, 1 = linear.
- `out_valid`  out  1  `y` and `sat` hold a result.
- `out_ready`  in  1  downstream accepts the result.
- `y`  out  DW  neuron output.
- `sat`  out  1  the scaled sum exceeded 2^DW-1 and `y` was clamped.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, MAC, ACT, DONE.
- IDLE: `in_ready`=1.
  - A capture occurs when `in_valid`&`in_ready` is high at a clock edge.
  - On capture, register `x_vec`, `w_vec`, `sigma` and `act_mode`; clear the accumulator; set the lane index to 0; go to MAC.
  - Port values after the capture edge are ignored until the next IDLE.
- MAC: each cycle, `acc <= acc + x[idx]*w[idx]`.
  - The product is full 2*DW-bit unsigned; lanes use their own weights.
  - `idx` increments from 0 to N_IN-1. When `idx`==N_IN-1, go to ACT.
  - MAC lasts exactly N_IN cycles.
- ACT: compute the result for one cycle, then go to DONE.
  - `scaled = acc >> DW`, width ACC_W-DW.
  - If `scaled` > 2^DW-1: `clip` = all ones and `sat`=1. Otherwise `clip` = `scaled[DW-1:0]` and `sat`=0.
  - `act_mode`=0: `y` = `clip` if `clip` > `sigma` (strictly greater), else `y`=0. `sat` still reports clamping even when `y` becomes 0.
  - `act_mode`=1: `y` = `clip`; `sigma` is ignored.
- DONE: `out_valid`=1; `y` and `sat` are held stable.
  - When `out_ready`=1 at an edge, go to IDLE.
  - `in_ready` stays 0 in DONE; no new capture overlaps a pending result.
- `in_ready` is a pure decode of state, with no combinational dependence on `in_valid`.
- `out_valid` does not depend on `out_ready`.
- `y` and `sat` change only on entry to DONE. After a handshake they keep their last value while `out_valid`=0.
- Reset (asynchronous, any state including mid-MAC): state=IDLE, `acc`=0, `idx`=0, `y`=0, `sat`=0, `out_valid`=0, `busy`=0.
  - `in_ready`=1 from the first edge after `rst_n` rises. Strictly, `in_ready` decodes IDLE, so it is 1 during reset itself.
  - A partial sum is discarded and no result is emitted.

## Timing
- Capture at edge T; MAC edges T+1..T+N_IN; ACT edge T+N_IN+1.
- `out_valid` rises after edge T+N_IN+1, i.e. latency N_IN+1 cycles from capture to valid.
- If `out_ready` is held high, the result handshakes at edge T+N_IN+2 and `in_ready` is 1 in the following cycle.
- Best-case initiation interval is N_IN+3 cycles (N_IN=4 gives 7).
- `in_valid` asserted during MAC, ACT or DONE is not accepted. The source must hold it until it sees `in_ready`.
- N_IN=1: MAC lasts one cycle and latency is 2.
- Critical path: one DW×DW multiply plus one ACC_W add per cycle. No pipeline register is required at DW=16.

## Test plan
All scenarios use N_IN=4, DW=16.
- Basic threshold: x lanes all 0x4000, w lanes all 0x8000, sigma=0x1000, mode 0 -> `y`=0x8000, `sat`=0; `out_valid` asserted 5 cycles after capture.
- Per-lane weights: x=(0x0100,0x0200,0x0300,0x0400) for lanes 0..3, w=(0x0400,0x0300,0x0200,0x0100), sigma=0x0010 -> `y`=0x0014. The same vector with sigma=0x0014 -> `y`=0x0000 (equality fails the threshold).
- Saturation: all x and w = 0xFFFF, mode 0, sigma=0 -> `y`=0xFFFF, `sat`=1. Mode 1 gives the same result. The accumulator does not wrap: the internal scaled value is 0x3FFF8.
- Backpressure: hold `out_ready` low for 6 cycles in DONE while `in_valid`=1 with a new vector. Required: `y`, `sat` and `out_valid` stable; `in_ready`=0; the second vector is captured only after the first handshake and yields its correct result.
- Reset mid-MAC: assert `rst_n` low two cycles after capture, release it, then send the basic vector. Required: no spurious `out_valid`; outputs are 0 during reset; the new result is 0x8000 with correct latency.
- Linear mode, small sum: x=(1,0,0,0), w=(0xFFFF,0,0,0), mode 1 -> `y`=0x0000, `sat`=0. With x0=2 the result is `y`=0x0001.
